// File: rtl/uart_pkt_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkt_pkg
//
// Purpose : Shared types and constants for the UART packet receiver.
//           Frame on the wire: SOF, LEN, LEN payload bytes, CSUM.
//           A frame is good when (LEN + sum(payload) + CSUM) mod 256 == 0.
//           SOF takes no part in the checksum.
//
// Contents: state_t     - receiver FSM states
//           SOF_DEFAULT - default start-of-frame byte
//           BYTE_W      - width of every frame field / stream byte
//           LEN_W       - width of the LEN field and of the length registers
//           csum_add    - 8-bit wrapping checksum accumulate
// -----------------------------------------------------------------------------
package uart_pkt_pkg;

  localparam int BYTE_W = 8;
  localparam int LEN_W  = 8;

  localparam logic [BYTE_W-1:0] SOF_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    HUNT,
    LEN,
    PAY,
    CSUM,
    SEND
  } state_t;

  // Checksum arithmetic is plain modulo-256 addition.
  function automatic logic [BYTE_W-1:0] csum_add(input logic [BYTE_W-1:0] a,
                                                 input logic [BYTE_W-1:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/uart_pkt_rx_if.sv
// -----------------------------------------------------------------------------
// uart_pkt_rx_if
//
// Purpose : Valid/ready byte stream carrying released packet payload.
//
// Signals : data  - payload byte
//           valid - data is valid
//           ready - sink accepts the byte when valid & ready
//           last  - final payload byte of the packet, qualified by valid
//
// Modports: master - stream source (the packet receiver)
//           slave  - stream sink
// -----------------------------------------------------------------------------
interface uart_pkt_rx_if;
  import uart_pkt_pkg::*;

  logic [BYTE_W-1:0] data;
  logic              valid;
  logic              ready;
  logic              last;

  modport master (
    output data,
    output valid,
    output last,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    input  last,
    output ready
  );

endinterface

// File: rtl/pkt_buf.sv
// -----------------------------------------------------------------------------
// pkt_buf
//
// Purpose : Payload buffer, DEPTH x 8 register array. One synchronous write
//           port and an asynchronous (combinational) read port. Contents are
//           not reset; a packet is always fully written before it is read.
//
// Ports   : clk   in   clock
//           we    in   write enable
//           waddr in   write address
//           wdata in   write data
//           raddr in   read address
//           rdata out  buffer[raddr], 0 for an address beyond DEPTH-1
// -----------------------------------------------------------------------------
module pkt_buf #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  // Each cell is its own register so that no array element has more than
  // one writer; the flat vector only feeds the read mux.
  logic [DEPTH-1:0][7:0] mem_flat;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_cell
      logic [7:0] cell_reg;

      always_ff @(posedge clk) begin
        if (we && (waddr == ADDR_W'(gi))) begin
          cell_reg <= wdata;
        end
      end

      assign mem_flat[gi] = cell_reg;
    end
  endgenerate

  // Extra top bit keeps the bound check correct when DEPTH == 2**ADDR_W.
  assign rdata = ({1'b0, raddr} < (ADDR_W + 1)'(DEPTH)) ? mem_flat[raddr] : 8'h00;

endmodule

// File: rtl/uart_pkt_rx.sv
// -----------------------------------------------------------------------------
// uart_pkt_rx
//
// Purpose : Framing stage behind a UART RX FIFO. Pops bytes from the FIFO's
//           show-ahead port, hunts for SOF, parses LEN / payload / CSUM,
//           buffers the payload and releases it as a valid/ready stream only
//           when the checksum passes. Bad frames are dropped and reported
//           with one-cycle status pulses.
//
// Parameters:
//   MAX_LEN     - largest accepted payload (1..255), also buffer depth
//   SOF         - start-of-frame byte
//   TIMEOUT_CYC - inter-byte timeout in clk cycles (timeout build only)
//
// Build option:
//   UART_PKT_TIMEOUT_EN - when defined, an idle counter runs in LEN/PAY/CSUM,
//                         clears on every consumed byte, and on reaching
//                         TIMEOUT_CYC returns to HUNT pulsing timeout_err.
//                         When undefined there is no counter, no TIMEOUT_CYC
//                         parameter and no timeout_err port.
//
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous active-low reset
//   rx_empty    in   FIFO empty flag
//   r_data      in   FIFO head byte, valid while rx_empty = 0
//   rd_uart     out  FIFO pop strobe (combinational)
//   pkt_out     if   payload stream (master side)
//   pkt_len     out  length of the packet being released
//   pkt_ok      out  pulse: checksum passed
//   csum_err    out  pulse: checksum mismatch
//   len_err     out  pulse: LEN > MAX_LEN
//   timeout_err out  pulse: inter-byte timeout (timeout build only)
// -----------------------------------------------------------------------------
module uart_pkt_rx
  import uart_pkt_pkg::*;
#(
  parameter int          MAX_LEN = 16,
  parameter logic [7:0]  SOF     = SOF_DEFAULT
`ifdef UART_PKT_TIMEOUT_EN
  ,
  parameter int          TIMEOUT_CYC = 100000
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_empty,
  input  logic [BYTE_W-1:0] r_data,
  output logic              rd_uart,
  uart_pkt_rx_if.master     pkt_out,
  output logic [LEN_W-1:0]  pkt_len,
  output logic              pkt_ok,
  output logic              csum_err,
  output logic              len_err
`ifdef UART_PKT_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);

  localparam int              ADDR_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN_B = LEN_W'(MAX_LEN);

  state_t              state_reg;
  state_t              state_next;

  logic [BYTE_W-1:0]   acc_reg;
  logic [LEN_W-1:0]    len_reg;
  logic [LEN_W-1:0]    pkt_len_reg;
  logic [LEN_W-1:0]    wptr_reg;
  logic [LEN_W-1:0]    rptr_reg;

  logic                out_valid_reg;
  logic                out_last_reg;
  logic [BYTE_W-1:0]   out_data_reg;

  logic                pkt_ok_reg;
  logic                csum_err_reg;
  logic                len_err_reg;

  logic                parse_state;
  logic                counting_state;
  logic                pop;
  logic                buf_we;
  logic                send_load;
  logic                send_done;
  logic                csum_good;
  logic                len_too_big;
  logic                pay_done;
  logic                timeout_hit;
  logic [BYTE_W-1:0]   buf_rdata;

  // Byte-level decisions shared by the next-state and datapath logic.
  assign csum_good   = (csum_add(acc_reg, r_data) == 8'h00);
  assign len_too_big = (r_data > MAX_LEN_B);
  assign pay_done    = (wptr_reg == (len_reg - 8'd1));

  // ---------------------------------------------------------------------------
  // Optional inter-byte timeout
  // ---------------------------------------------------------------------------
`ifdef UART_PKT_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

  logic [IDLE_W-1:0] idle_cnt_reg;
  logic              timeout_err_reg;

  // The cycle that would bring the count to TIMEOUT_CYC is the one that fires.
  assign timeout_hit = counting_state && !pop &&
                       (idle_cnt_reg == IDLE_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin : timeout_ff
    if (!reset) begin
      idle_cnt_reg    <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      timeout_err_reg <= timeout_hit;
      if (pop || !counting_state || timeout_hit) begin
        idle_cnt_reg <= '0;
      end else begin
        idle_cnt_reg <= idle_cnt_reg + 1'b1;
      end
    end
  end

  assign timeout_err = timeout_err_reg;
`else
  assign timeout_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin : fsm_state_ff
    if (!reset) begin
      state_reg <= HUNT;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin : fsm_next_comb
    state_next = state_reg;
    case (state_reg)
      HUNT: begin
        if (pop && (r_data == SOF)) begin
          state_next = LEN;
        end
      end
      LEN: begin
        if (pop) begin
          // An oversize LEN byte is dropped outright, never re-tried as SOF.
          if (len_too_big) begin
            state_next = HUNT;
          end else if (r_data == 8'd0) begin
            state_next = CSUM;
          end else begin
            state_next = PAY;
          end
        end
      end
      PAY: begin
        if (pop && pay_done) begin
          state_next = CSUM;
        end
      end
      CSUM: begin
        if (pop) begin
          // Empty packets are acknowledged but never streamed.
          if (csum_good && (len_reg != 8'd0)) begin
            state_next = SEND;
          end else begin
            state_next = HUNT;
          end
        end
      end
      SEND: begin
        if (send_done) begin
          state_next = HUNT;
        end
      end
      default: state_next = HUNT;
    endcase

    if (timeout_hit) begin
      state_next = HUNT;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs / strobes
  // ---------------------------------------------------------------------------
  always_comb begin : fsm_out_comb
    parse_state    = 1'b0;
    counting_state = 1'b0;
    case (state_reg)
      HUNT:           parse_state = 1'b1;
      LEN, PAY, CSUM: begin
        parse_state    = 1'b1;
        counting_state = 1'b1;
      end
      default: begin
        parse_state    = 1'b0;
        counting_state = 1'b0;
      end
    endcase

    pop    = parse_state && !rx_empty;
    buf_we = pop && (state_reg == PAY);

    // The output register refills whenever it is empty or being drained,
    // as long as buffered bytes remain.
    send_load = (state_reg == SEND) && (rptr_reg < len_reg) &&
                (!out_valid_reg || pkt_out.ready);
    send_done = (state_reg == SEND) && out_valid_reg && pkt_out.ready &&
                out_last_reg;
  end

  // Reset also forces the pop strobe low so the FIFO is untouched during reset.
  assign rd_uart = pop && reset;

  // ---------------------------------------------------------------------------
  // Datapath: checksum, pointers, status pulses, output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin : datapath_ff
    if (!reset) begin
      acc_reg       <= '0;
      len_reg       <= '0;
      pkt_len_reg   <= '0;
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_data_reg  <= '0;
      pkt_ok_reg    <= 1'b0;
      csum_err_reg  <= 1'b0;
      len_err_reg   <= 1'b0;
    end else begin
      pkt_ok_reg   <= 1'b0;
      csum_err_reg <= 1'b0;
      len_err_reg  <= 1'b0;

      if (pop) begin
        case (state_reg)
          LEN: begin
            if (len_too_big) begin
              len_err_reg <= 1'b1;
            end else begin
              // LEN seeds the checksum; a zero LEN seeds it with 0.
              len_reg  <= r_data;
              acc_reg  <= r_data;
              wptr_reg <= '0;
              if (r_data != 8'd0) begin
                pkt_len_reg <= r_data;
              end
            end
          end
          PAY: begin
            acc_reg  <= csum_add(acc_reg, r_data);
            wptr_reg <= wptr_reg + 8'd1;
          end
          CSUM: begin
            if (csum_good) begin
              pkt_ok_reg <= 1'b1;
              rptr_reg   <= '0;
            end else begin
              csum_err_reg <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end

      // rptr counts bytes moved into the output register; the register adds
      // the second cycle of latency between CSUM and the first valid.
      if (send_load) begin
        out_data_reg  <= buf_rdata;
        out_last_reg  <= (rptr_reg == (len_reg - 8'd1));
        out_valid_reg <= 1'b1;
        rptr_reg      <= rptr_reg + 8'd1;
      end else if (send_done) begin
        out_valid_reg <= 1'b0;
        out_last_reg  <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Payload buffer
  // ---------------------------------------------------------------------------
  pkt_buf #(
    .DEPTH  (MAX_LEN),
    .ADDR_W (ADDR_W)
  ) u_pkt_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wptr_reg[ADDR_W-1:0]),
    .wdata (r_data),
    .raddr (rptr_reg[ADDR_W-1:0]),
    .rdata (buf_rdata)
  );

  assign pkt_out.data  = out_data_reg;
  assign pkt_out.valid = out_valid_reg;
  assign pkt_out.last  = out_last_reg;
  assign pkt_len       = pkt_len_reg;
  assign pkt_ok        = pkt_ok_reg;
  assign csum_err      = csum_err_reg;
  assign len_err       = len_err_reg;

endmodule

// File: tb/tb_uart_pkt_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_pkt_rx
//
// Purpose : Directed self-checking bench for uart_pkt_rx. A queue models the
//           show-ahead UART RX FIFO. A table of frames with hand-computed
//           outcomes is applied in a loop; back-pressure, maximum length and
//           reset-during-payload are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_uart_pkt_rx;

  typedef struct packed {
    int          n;          // number of FIFO bytes
    logic [63:0] bytes;      // byte i at [8*i +: 8]
    int          exp_ok;
    int          exp_cerr;
    int          exp_lerr;
    int          exp_n;      // streamed payload bytes
    logic [31:0] exp_data;   // stream byte i at [8*i +: 8]
    int          exp_len;
    int          exp_pops;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_empty;
  logic [7:0] r_data;
  logic       rd_uart;
  logic [7:0] pkt_len;
  logic       pkt_ok;
  logic       csum_err;
  logic       len_err;
`ifdef UART_PKT_TIMEOUT_EN
  logic       timeout_err;
`endif

  uart_pkt_rx_if bus ();

  always #5 clk = ~clk;

  uart_pkt_rx #(
    .MAX_LEN (16),
    .SOF     (8'hA5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_empty (rx_empty),
    .r_data   (r_data),
    .rd_uart  (rd_uart),
    .pkt_out  (bus),
    .pkt_len  (pkt_len),
    .pkt_ok   (pkt_ok),
    .csum_err (csum_err),
    .len_err  (len_err)
`ifdef UART_PKT_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  logic [7:0] fifo_q[$];
  logic [7:0] got_data[$];
  logic       got_last[$];

  int n_cmp = 0;
  int n_bad = 0;
  int pops, n_ok, n_cerr, n_lerr, multi, cyc;
  int last_pop_cyc, ok_cyc, first_valid_cyc;
  int saw_valid;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic check_stream(input string tag, input int idx,
                              input logic [7:0] eb, input logic el);
    n_cmp++;
    if (idx >= got_data.size()) begin
      n_bad++;
      $display("FAIL %s stream[%0d]: byte missing, expected data 0x%02h last %0b",
               tag, idx, eb, el);
    end else if (got_data[idx] !== eb || got_last[idx] !== el) begin
      n_bad++;
      $display("FAIL %s stream[%0d]: got data 0x%02h last %0b, expected data 0x%02h last %0b",
               tag, idx, got_data[idx], got_last[idx], eb, el);
    end
  endtask

  task automatic clear_stats();
    pops = 0; n_ok = 0; n_cerr = 0; n_lerr = 0; multi = 0; cyc = 0;
    last_pop_cyc = -100; ok_cyc = -100; first_valid_cyc = -1; saw_valid = 0;
    got_data.delete();
    got_last.delete();
  endtask

  // One clock cycle: present the FIFO head, sample away from the edge,
  // then pop the head if the DUT strobed rd_uart. Entered and left at negedge.
  task automatic tick();
    logic pop_now;
    rx_empty = (fifo_q.size() == 0);
    r_data   = rx_empty ? 8'h00 : fifo_q[0];
    #1;
    pop_now = rd_uart;
    if (rd_uart) begin
      pops++;
      last_pop_cyc = cyc;
    end
    if (pkt_ok) begin
      n_ok++;
      ok_cyc = cyc;
    end
    if (csum_err) n_cerr++;
    if (len_err)  n_lerr++;
    if ((int'(pkt_ok) + int'(csum_err) + int'(len_err)) > 1) multi++;
    if (bus.valid) begin
      saw_valid = 1;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.ready) begin
        got_data.push_back(bus.data);
        got_last.push_back(bus.last);
      end
    end
    @(posedge clk);
    if (pop_now && fifo_q.size() > 0) void'(fifo_q.pop_front());
    cyc++;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_uart"},  int'(rd_uart),   0);
    check({tag, "_valid"},    int'(bus.valid), 0);
    check({tag, "_last"},     int'(bus.last),  0);
    check({tag, "_data"},     int'(bus.data),  0);
    check({tag, "_pkt_len"},  int'(pkt_len),   0);
    check({tag, "_pkt_ok"},   int'(pkt_ok),    0);
    check({tag, "_csum_err"}, int'(csum_err),  0);
    check({tag, "_len_err"},  int'(len_err),   0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vecs[6];
    string tag;
    int    hold_bad;

    // A5 03 11 22 33 97 : 3+11+22+33 = 69, +97 = 100 -> good
    vecs[0] = '{n: 6, bytes: 64'h0000_9733_2211_03A5, exp_ok: 1, exp_cerr: 0, exp_lerr: 0,
                exp_n: 3, exp_data: 32'h0033_2211, exp_len: 3, exp_pops: 6};
    // garbage 00 FF 5A, then empty packet A5 00 00
    vecs[1] = '{n: 6, bytes: 64'h0000_0000_A55A_FF00, exp_ok: 1, exp_cerr: 0, exp_lerr: 0,
                exp_n: 0, exp_data: 32'h0, exp_len: 3, exp_pops: 6};
    // A5 02 01 02 00 : sum 05 -> checksum error
    vecs[2] = '{n: 5, bytes: 64'h0000_0000_0201_02A5, exp_ok: 0, exp_cerr: 1, exp_lerr: 0,
                exp_n: 0, exp_data: 32'h0, exp_len: 2, exp_pops: 5};
    // A5 02 01 02 FB : 05 + FB = 100 -> good
    vecs[3] = '{n: 5, bytes: 64'h0000_00FB_0201_02A5, exp_ok: 1, exp_cerr: 0, exp_lerr: 0,
                exp_n: 2, exp_data: 32'h0000_0201, exp_len: 2, exp_pops: 5};
    // A5 11 (17 > 16) then A5 01 7F 80 : 01+7F+80 = 100 -> good
    vecs[4] = '{n: 6, bytes: 64'h0000_807F_01A5_11A5, exp_ok: 1, exp_cerr: 0, exp_lerr: 1,
                exp_n: 1, exp_data: 32'h0000_007F, exp_len: 1, exp_pops: 6};
    // A5 04 FF FF FF FF 00 : 04 + 3FC = 400 -> good, checksum wraps
    vecs[5] = '{n: 7, bytes: 64'h0000_FFFF_FFFF_04A5, exp_ok: 1, exp_cerr: 0, exp_lerr: 0,
                exp_n: 4, exp_data: 32'hFFFF_FFFF, exp_len: 4, exp_pops: 7};

    reset    = 1'b0;
    rx_empty = 1'b1;
    r_data   = 8'h00;
    bus.ready = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    // ---------------- table-driven frames ----------------
    for (int v = 0; v < 6; v++) begin
      clear_stats();
      for (int b = 0; b < vecs[v].n; b++) fifo_q.push_back(vecs[v].bytes[8*b +: 8]);
      repeat (vecs[v].n + vecs[v].exp_n + 8) tick();

      tag = $sformatf("vec%0d", v);
      check({tag, "_pops"},     pops,            vecs[v].exp_pops);
      check({tag, "_pkt_ok"},   n_ok,            vecs[v].exp_ok);
      check({tag, "_csum_err"}, n_cerr,          vecs[v].exp_cerr);
      check({tag, "_len_err"},  n_lerr,          vecs[v].exp_lerr);
      check({tag, "_pkt_len"},  int'(pkt_len),   vecs[v].exp_len);
      check({tag, "_n_bytes"},  got_data.size(), vecs[v].exp_n);
      check({tag, "_any_valid"}, saw_valid,      (vecs[v].exp_n > 0) ? 1 : 0);
      check({tag, "_multi_pulse"}, multi,        0);
      for (int i = 0; i < vecs[v].exp_n; i++)
        check_stream(tag, i, vecs[v].exp_data[8*i +: 8], (i == vecs[v].exp_n - 1));
      if (vecs[v].exp_n > 0)
        check({tag, "_valid_latency"}, first_valid_cyc - last_pop_cyc, 2);
      if (vecs[v].exp_ok > 0)
        check({tag, "_ok_latency"}, ok_cyc - last_pop_cyc, 1);
      $display("%s: pops=%0d ok=%0d csum_err=%0d len_err=%0d bytes=%0d pkt_len=%0d",
               tag, pops, n_ok, n_cerr, n_lerr, got_data.size(), pkt_len);
    end

    // ---------------- back-pressure ----------------
    clear_stats();
    bus.ready = 1'b0;
    fifo_q.push_back(8'hA5); fifo_q.push_back(8'h03); fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h22); fifo_q.push_back(8'h33); fifo_q.push_back(8'h97);
    fifo_q.push_back(8'hA5); fifo_q.push_back(8'h01); fifo_q.push_back(8'h7F);
    fifo_q.push_back(8'h80);
    for (int i = 0; i < 20 && first_valid_cyc < 0; i++) tick();
    check("bp_valid_seen", saw_valid, 1);
    hold_bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.valid !== 1'b1 || bus.data !== 8'h11 || bus.last !== 1'b0 || rd_uart !== 1'b0)
        hold_bad++;
    end
    check("bp_hold_unstable_cycles", hold_bad, 0);
    check("bp_hold_fifo_left", fifo_q.size(), 4);
    check("bp_hold_pops", pops, 6);
    bus.ready = 1'b1;
    repeat (20) tick();
    check("bp_n_bytes", got_data.size(), 4);
    check_stream("bp", 0, 8'h11, 1'b0);
    check_stream("bp", 1, 8'h22, 1'b0);
    check_stream("bp", 2, 8'h33, 1'b1);
    check_stream("bp", 3, 8'h7F, 1'b1);
    check("bp_pkt_ok", n_ok, 2);
    check("bp_pops", pops, 10);
    check("bp_fifo_left", fifo_q.size(), 0);
    $display("backpressure: pops=%0d ok=%0d bytes=%0d hold_bad=%0d",
             pops, n_ok, got_data.size(), hold_bad);

    // ---------------- LEN == MAX_LEN ----------------
    clear_stats();
    fifo_q.push_back(8'hA5);
    fifo_q.push_back(8'h10);
    for (int i = 0; i < 16; i++) fifo_q.push_back(8'h01);
    fifo_q.push_back(8'hE0);  // 10 + 16*01 = 20, + E0 = 100
    repeat (19 + 16 + 8) tick();
    check("max_pops", pops, 19);
    check("max_pkt_ok", n_ok, 1);
    check("max_csum_err", n_cerr, 0);
    check("max_len_err", n_lerr, 0);
    check("max_pkt_len", int'(pkt_len), 16);
    check("max_n_bytes", got_data.size(), 16);
    for (int i = 0; i < 16; i++) check_stream("max", i, 8'h01, (i == 15));
    check("max_valid_latency", first_valid_cyc - last_pop_cyc, 2);
    $display("max_len: pops=%0d ok=%0d bytes=%0d pkt_len=%0d",
             pops, n_ok, got_data.size(), pkt_len);

    // ---------------- reset during payload ----------------
    clear_stats();
    fifo_q.push_back(8'hA5); fifo_q.push_back(8'h03); fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h22); fifo_q.push_back(8'h33); fifo_q.push_back(8'h97);
    fifo_q.push_back(8'hA5); fifo_q.push_back(8'h01); fifo_q.push_back(8'h7F);
    fifo_q.push_back(8'h80);
    repeat (4) tick();
    check("rst_pre_pops", pops, 4);
    check("rst_pre_pkt_len", int'(pkt_len), 3);
    rx_empty = 1'b0;
    r_data   = fifo_q[0];
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("rst_mid");
    @(negedge clk);
    reset = 1'b1;
    clear_stats();
    repeat (16) tick();
    check("rst_post_pops", pops, 6);
    check("rst_post_pkt_ok", n_ok, 1);
    check("rst_post_csum_err", n_cerr, 0);
    check("rst_post_len_err", n_lerr, 0);
    check("rst_post_pkt_len", int'(pkt_len), 1);
    check("rst_post_n_bytes", got_data.size(), 1);
    check_stream("rst_post", 0, 8'h7F, 1'b1);
    check("rst_post_fifo_left", fifo_q.size(), 0);
    $display("reset_mid_pay: pops=%0d ok=%0d bytes=%0d pkt_len=%0d",
             pops, n_ok, got_data.size(), pkt_len);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
